// File: rtl/popcount_pkg.sv
// rtl/popcount_pkg.sv - shared types, activation encoding and width helper for the ternary neuron
package popcount_pkg;

  typedef logic [1:0] act_t;

  localparam act_t ACT_POS  = 2'b01;
  localparam act_t ACT_ZERO = 2'b00;
  localparam act_t ACT_NEG  = 2'b11;

  typedef enum logic [1:0] {ACCUM, DRAIN, EMIT} state_t;

  // Signed width that holds +/- chunk_w*n_beats without overflow
  function automatic int acc_width(input int chunk_w, input int n_beats);
    return $clog2(chunk_w * n_beats + 1) + 1;
  endfunction

endpackage

// File: rtl/popcount_chunk.sv
// rtl/popcount_chunk.sv - combinational population count of a W-bit word
module popcount_chunk #(
  parameter int W = 24
) (
  input  logic [W-1:0]             din,
  output logic [$clog2(W+1)-1:0]   cnt
);

  localparam int CW = $clog2(W + 1);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CW'(din[i]);
    end
  end

endmodule

// File: rtl/ternary_neuron_seq.sv
// rtl/ternary_neuron_seq.sv - streamed ternary neuron: per-beat pos/neg popcount, signed accumulate, ternary activation
// Build option POPCNT_TRUNC_EN: clear bit 0 of each per-beat popcount (approximate mode)
module ternary_neuron_seq
  import popcount_pkg::*;
#(
  parameter int  CHUNK_W = 24,
  parameter int  N_BEATS = 4,
  localparam int ACC_W   = acc_width(CHUNK_W, N_BEATS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHUNK_W-1:0]           in_data,
  input  logic [CHUNK_W*N_BEATS-1:0]   pos_mask,
  input  logic [CHUNK_W*N_BEATS-1:0]   neg_mask,
  input  logic signed [ACC_W-1:0]      thr_hi,
  input  logic signed [ACC_W-1:0]      thr_lo,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_W-1:0]      out_sum,
  output logic [1:0]                   out_act
);

  localparam int PW = $clog2(CHUNK_W + 1);
  localparam int BW = $clog2(N_BEATS + 1);

  state_t                   state, state_nxt;
  logic [BW-1:0]            beat_cnt;
  logic [CHUNK_W-1:0]       pos_slice, neg_slice;
  logic [PW-1:0]            p_raw, n_raw, p_val, n_val, s1_p, s1_n;
  logic                     s1_valid;
  logic signed [ACC_W-1:0]  acc, delta, acc_sum;
  logic                     accept, last_beat, out_hs;
  act_t                     act_nxt;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == EMIT);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign last_beat = (beat_cnt == BW'(N_BEATS - 1));

  assign pos_slice = pos_mask[int'(beat_cnt)*CHUNK_W +: CHUNK_W];
  assign neg_slice = neg_mask[int'(beat_cnt)*CHUNK_W +: CHUNK_W];

  popcount_chunk #(.W(CHUNK_W)) u_pos_cnt (.din(in_data & pos_slice), .cnt(p_raw));
  popcount_chunk #(.W(CHUNK_W)) u_neg_cnt (.din(in_data & neg_slice), .cnt(n_raw));

`ifdef POPCNT_TRUNC_EN
  assign p_val = p_raw & ~PW'(1);
  assign n_val = n_raw & ~PW'(1);
`else
  assign p_val = p_raw;
  assign n_val = n_raw;
`endif

  assign delta   = $signed(ACC_W'(s1_p)) - $signed(ACC_W'(s1_n));
  assign acc_sum = s1_valid ? acc + delta : acc;

  // +1 is tested first so it wins when thr_lo > thr_hi
  always_comb begin
    act_nxt = ACT_ZERO;
    if (acc_sum > thr_hi)      act_nxt = ACT_POS;
    else if (acc_sum < thr_lo) act_nxt = ACT_NEG;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACCUM:   if (accept && last_beat) state_nxt = DRAIN;
      DRAIN:   state_nxt = EMIT;
      EMIT:    if (out_hs) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_n     <= '0;
      acc      <= '0;
      out_sum  <= '0;
      out_act  <= ACT_ZERO;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_p <= p_val;
        s1_n <= n_val;
      end
      if (out_hs) begin
        beat_cnt <= '0;
        acc      <= '0;
      end else begin
        if (accept) beat_cnt <= beat_cnt + 1'b1;
        acc <= acc_sum;
      end
      // DRAIN is the cycle the last beat leaves S1; result and thresholds are captured here
      if (state == DRAIN) begin
        out_sum <= acc_sum;
        out_act <= act_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ternary_neuron_seq.sv
// tb/tb_ternary_neuron_seq.sv - scoreboard bench for ternary_neuron_seq
module tb_ternary_neuron_seq;
  import popcount_pkg::*;

  localparam int CW  = 24;
  localparam int NB  = 4;
  localparam int TOT = CW * NB;
  localparam int AW  = $clog2(TOT + 1) + 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [CW-1:0]         in_data = '0;
  logic [TOT-1:0]        pos_mask = '0;
  logic [TOT-1:0]        neg_mask = '0;
  logic signed [AW-1:0]  thr_hi = '0;
  logic signed [AW-1:0]  thr_lo = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic signed [AW-1:0]  out_sum;
  logic [1:0]            out_act;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int seen = 0;
  int last_acc_cyc = 0;
  int rdy_mode = 0;

  typedef struct {
    int         sum;
    logic [1:0] act;
  } exp_t;

  exp_t sb[$];

  ternary_neuron_seq #(.CHUNK_W(CW), .N_BEATS(NB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .pos_mask (pos_mask),
    .neg_mask (neg_mask),
    .thr_hi   (thr_hi),
    .thr_lo   (thr_lo),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_act  (out_act)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 2) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: sum over every bit of (x&pos) - (x&neg), per beat, then threshold
  function automatic exp_t model(input logic [TOT-1:0] x, input logic [TOT-1:0] pos,
                                 input logic [TOT-1:0] neg, input int hi, input int lo);
    exp_t e;
    int p, n;
    e.sum = 0;
    for (int k = 0; k < NB; k++) begin
      p = 0;
      n = 0;
      for (int j = 0; j < CW; j++) begin
        p += int'(x[k*CW+j] & pos[k*CW+j]);
        n += int'(x[k*CW+j] & neg[k*CW+j]);
      end
`ifdef POPCNT_TRUNC_EN
      p = p - (p % 2);
      n = n - (n % 2);
`endif
      e.sum += p - n;
    end
    e.act = (e.sum > hi) ? ACT_POS : (e.sum < lo) ? ACT_NEG : ACT_ZERO;
    return e;
  endfunction

  // Monitor: latency, backpressure stability, in_ready in EMIT, scoreboard compare
  logic                  prev_v = 1'b0;
  logic                  prev_r = 1'b0;
  logic signed [AW-1:0]  prev_sum = '0;
  logic [1:0]            prev_act = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) chk("latency", cyc - last_acc_cyc, 2);
      if (prev_v && !prev_r) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_sum", out_sum, prev_sum);
        chk("hold_act", out_act, prev_act);
      end
      if (out_valid) chk("in_ready_emit", in_ready, 0);
      if (out_valid && out_ready) begin
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sum", out_sum, e.sum);
          chk("act", out_act, e.act);
        end
        seen++;
      end
      prev_v   = out_valid;
      prev_r   = out_ready;
      prev_sum = out_sum;
      prev_act = out_act;
    end
  end

  task automatic run_eval(input logic [TOT-1:0] x, input logic [TOT-1:0] pos,
                          input logic [TOT-1:0] neg, input int hi, input int lo,
                          input int gapmax, input bit keep_valid);
    exp_t e;
    int   target;
    int   wc;
    e        = model(x, pos, neg, hi, lo);
    pos_mask = pos;
    neg_mask = neg;
    thr_hi   = AW'(hi);
    thr_lo   = AW'(lo);
    target   = seen + 1;
    for (int k = 0; k < NB; k++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, gapmax)) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = x[k*CW +: CW];
      wc = 0;
      do begin
        @(negedge clk);
        wc++;
      end while (!in_ready && wc < 100);
      chk("beat_accept", in_ready, 1);
      if (k == NB - 1) begin
        last_acc_cyc = cyc;
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    in_valid = keep_valid;
    in_data  = CW'($urandom);
    wc = 0;
    while (seen < target && wc < 200) begin
      @(negedge clk);
      wc++;
    end
    chk("result_seen", seen >= target, 1);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cycles=%0d required=finish", cyc);
    $fatal(1);
  end

  initial begin
    logic [TOT-1:0] ones;
    logic [TOT-1:0] x, p, n;
    int hi, lo, wc;
    ones = '1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_act", out_act, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_eval(ones, ones, '0, 10, -10, 0, 1'b0);
    run_eval(ones, '0, ones, 10, -10, 1, 1'b0);
    run_eval(ones, ones, ones, 10, -10, 2, 1'b0);
    run_eval(ones, TOT'(24'hFFF), '0, 12, -10, 0, 1'b0);
    run_eval(ones, TOT'(24'h1F), '0, 10, -10, 0, 1'b0);
    run_eval(ones, TOT'(24'h1F), '0, 10, 20, 0, 1'b0);

    // Backpressure: hold out_ready low 5 cycles in EMIT with in_valid high
    rdy_mode = 2;
    fork
      run_eval(ones, ones, '0, 10, -10, 0, 1'b1);
      begin
        wc = 0;
        while (!out_valid && wc < 100) begin
          @(negedge clk);
          wc++;
        end
        chk("bp_valid_seen", out_valid, 1);
        repeat (5) @(posedge clk);
        rdy_mode = 0;
      end
    join

    // Reset in the middle of an evaluation
    pos_mask = ones;
    neg_mask = '0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_data  = '1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_sum", out_sum, 0);
      chk("mid_rst_out_act", out_act, 0);
      chk("mid_rst_in_ready", in_ready, 1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_eval(ones, TOT'(28'h7F0_0000), '0, 20, -20, 0, 1'b0);

    rdy_mode = 1;
    for (int i = 0; i < 20; i++) begin
      x  = {$urandom, $urandom, $urandom};
      p  = {$urandom, $urandom, $urandom};
      n  = {$urandom, $urandom, $urandom};
      if (i % 3 == 0) n = n & p;
      hi = int'($urandom_range(0, 2 * 20)) - 20;
      lo = int'($urandom_range(0, 2 * 20)) - 20;
      run_eval(x, p, n, hi, lo, 3, i[0]);
    end
    rdy_mode = 0;

    repeat (4) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
